// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry and loader FSM state encodings.
package regfile_pkg;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2
    } state_e;
endpackage

// File: rtl/rf_checksum.sv
// rf_checksum: XOR accumulator with synchronous clear; clear wins over enable.
module rf_checksum #(
    parameter int W = regfile_pkg::DATA_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sum_o
);
    logic [W-1:0] sum_q;
    always_ff @(posedge clk_i) begin
        sum_q <= (rst_i || clr_i) ? '0 : en_i ? sum_q ^ data_i : sum_q;
    end
    assign sum_o = sum_q;
endmodule

// File: rtl/rf_loader.sv
// rf_loader: streams valid/ready words into consecutive register-file addresses.
// Define RF_LOADER_VERIFY_EN to add a read-back pass comparing XOR checksums (Ard1/Error).
module rf_loader #(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W:0]   Count,
    input  logic [DATA_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    output logic [ADDR_W-1:0] Awr,
    output logic [DATA_W-1:0] Din,
    output logic              WrEn,
    output logic [ADDR_W-1:0] Ard1,
    input  logic [DATA_W-1:0] Dout1,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);
    import regfile_pkg::*;

    localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(NUM_REGS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, awr_q, awr_d;
    logic [ADDR_W:0]   left_q, left_d, n_clamp;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wr_q, done_q, done_d;
    logic              take, beat, load_end;

    assign take     = state_q == ST_IDLE && Start;
    assign n_clamp  = Count > MAX_N ? MAX_N : Count;
    assign InReady  = state_q == ST_LOAD && left_q != '0;
    assign beat     = InReady && InValid;
    // left_q reaches zero on the last beat, so this is the last write cycle
    assign load_end = state_q == ST_LOAD && left_q == '0;
    assign Busy     = state_q != ST_IDLE;
    assign {Awr, Din, WrEn, Done} = {awr_q, din_q, wr_q, done_q};

`ifdef RF_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] base_q, ard_q;
    logic [ADDR_W:0]   n_q, vleft_q;
    logic [DATA_W-1:0] in_sum, rb_sum;
    logic              err_q, in_en, rb_en, verify_end;

    assign in_en      = beat && addr_q != '0;
    assign rb_en      = state_q == ST_VERIFY && ard_q != '0;
    assign verify_end = state_q == ST_VERIFY && vleft_q == (ADDR_W+1)'(1);
    assign {Ard1, Error} = {ard_q, err_q};

    rf_checksum #(.W(DATA_W)) u_in_sum (
        .clk_i(Clk), .rst_i(Rst), .clr_i(take), .en_i(in_en), .data_i(InData), .sum_o(in_sum)
    );
    rf_checksum #(.W(DATA_W)) u_rb_sum (
        .clk_i(Clk), .rst_i(Rst), .clr_i(take), .en_i(rb_en), .data_i(Dout1), .sum_o(rb_sum)
    );

    // the final read is folded in combinationally so Error lands with Done
    always_ff @(posedge Clk) begin
        if (Rst) begin
            base_q  <= '0;
            n_q     <= '0;
            ard_q   <= '0;
            vleft_q <= '0;
            err_q   <= 1'b0;
        end else begin
            base_q  <= take ? BaseAddr : base_q;
            n_q     <= take ? n_clamp : n_q;
            ard_q   <= load_end ? base_q : verify_end ? '0 : state_q == ST_VERIFY ? ard_q + 1'b1 : ard_q;
            vleft_q <= load_end ? n_q : state_q == ST_VERIFY ? vleft_q - 1'b1 : vleft_q;
            err_q   <= take ? 1'b0 : verify_end ? in_sum != (rb_sum ^ (rb_en ? Dout1 : '0)) : err_q;
        end
    end
`else
    logic unused_dout;
    assign unused_dout   = ^Dout1;
    assign {Ard1, Error} = '0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        awr_d   = beat ? addr_q : awr_q;
        din_d   = beat ? InData : din_q;
        done_d  = 1'b0;
        if (take) begin
            addr_d  = BaseAddr;
            left_d  = n_clamp;
            state_d = Count == '0 ? ST_IDLE : ST_LOAD;
            done_d  = Count == '0;
        end else if (beat) begin
            addr_d = addr_q + 1'b1;
            left_d = left_q - 1'b1;
        end else if (load_end) begin
`ifdef RF_LOADER_VERIFY_EN
            state_d = ST_VERIFY;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
        end
`ifdef RF_LOADER_VERIFY_EN
        else if (verify_end) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            awr_q   <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            awr_q   <= awr_d;
            din_q   <= din_d;
            wr_q    <= beat;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_rf_loader.sv
// tb_rf_loader: directed scenarios for rf_loader against a behavioural register file.
module tb_rf_loader;
`ifdef RF_LOADER_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif
    logic        Clk = 1'b0;
    logic        Rst, Start, InValid, InReady, WrEn, Busy, Done, Error, corrupt;
    logic [4:0]  BaseAddr, Awr, Ard1;
    logic [5:0]  Count;
    logic [31:0] InData, Din, Dout1;
    logic [31:0] rf [32];
    logic [4:0]  wa [$];
    logic [4:0]  ra [$];
    logic [31:0] wd [$];
    int checks = 0;
    int errors = 0;

    rf_loader dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .BaseAddr(BaseAddr), .Count(Count),
        .InData(InData), .InValid(InValid), .InReady(InReady), .Awr(Awr), .Din(Din),
        .WrEn(WrEn), .Ard1(Ard1), .Dout1(Dout1), .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) if (WrEn && Awr != 5'd0) rf[Awr] <= Din;
    assign Dout1 = Ard1 == 5'd0 ? 32'h0 : rf[Ard1] ^ ((corrupt && Ard1 == 5'd5) ? 32'h100 : 32'h0);

    task automatic tick();
        @(posedge Clk);
        #1;
        if (WrEn) begin wa.push_back(Awr); wd.push_back(Din); end
        if (Busy && !InReady && !WrEn) ra.push_back(Ard1);
    endtask

    task automatic start(input logic [4:0] b, input logic [5:0] c);
        wa.delete(); wd.delete(); ra.delete();
        BaseAddr = b; Count = c; Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!Done && n < 200) begin tick(); n++; end
        if (!Done) n = -1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; InValid = 1'b0; InData = '0; BaseAddr = '0; Count = '0; corrupt = 1'b0;
        tick(); tick();
        checks++;
        if ({InReady, WrEn, Busy, Done, Error, Awr, Ard1, Din} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", {InReady, WrEn, Busy, Done, Error, Awr, Ard1, Din});
        end
        Rst = 1'b0;
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL reset_idle got busy=%b done=%b want 0 0", Busy, Done);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d [3];
        int n;
        d = '{32'h11, 32'h22, 32'h33};
        start(5'd4, 6'd3);
        checks++;
        if (Busy !== 1'b1 || InReady !== 1'b1 || Done !== 1'b0) begin
            errors++; $display("FAIL basic_start got busy=%b rdy=%b done=%b want 1 1 0", Busy, InReady, Done);
        end
        InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            InData = d[i];
            tick();
            checks++;
            if (WrEn !== 1'b1 || Awr !== 5'(4 + i) || Din !== d[i]) begin
                errors++; $display("FAIL basic_write%0d got we=%b a=%0d d=%h want 1 %0d %h", i, WrEn, Awr, Din, 4 + i, d[i]);
            end
        end
        InValid = 1'b0;
        checks++;
        if (InReady !== 1'b0) begin errors++; $display("FAIL basic_ready_drop got %b want 0", InReady); end
        wait_done(n);
        checks++;
        if (n !== 1 + VER * 3 || Busy !== 1'b0 || Error !== 1'b0) begin
            errors++; $display("FAIL basic_done got lat=%0d busy=%b err=%b want %0d 0 0", n, Busy, Error, 1 + VER * 3);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || wa.size() != 3) begin
            errors++; $display("FAIL basic_pulse got done=%b writes=%0d want 0 3", Done, wa.size());
        end
        checks++;
        if (ra.size() != VER * 3) begin errors++; $display("FAIL basic_reads got %0d want %0d", ra.size(), VER * 3); end
        for (int i = 0; i < ra.size(); i++) begin
            checks++;
            if (ra[i] !== 5'(4 + i)) begin errors++; $display("FAIL basic_ard%0d got %0d want %0d", i, ra[i], 4 + i); end
        end
    endtask

    task automatic test_stall();
        logic v [5];
        logic [4:0] ea [3];
        logic [31:0] ed [3];
        int n;
        v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ea = '{5'd10, 5'd11, 5'd12};
        ed = '{32'hA0, 32'hA3, 32'hA4};
        start(5'd10, 6'd3);
        for (int i = 0; i < 5; i++) begin
            InValid = v[i];
            InData = 32'hA0 + i;
            Start = i == 1;
            BaseAddr = 5'd20; Count = 6'd1;
            tick();
            checks++;
            if (WrEn !== v[i]) begin errors++; $display("FAIL stall_we%0d got %b want %b", i, WrEn, v[i]); end
        end
        Start = 1'b0; InValid = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 1 + VER * 3 || wa.size() != 3) begin
            errors++; $display("FAIL stall_done got lat=%0d writes=%0d want %0d 3", n, wa.size(), 1 + VER * 3);
        end
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                errors++; $display("FAIL stall_write%0d got a=%0d d=%h want %0d %h", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [4:0] ea [4];
        int n;
        ea = '{5'd30, 5'd31, 5'd0, 5'd1};
        start(5'd30, 6'd4);
        InValid = 1'b1;
        for (int i = 0; i < 4; i++) begin InData = 32'h100 * (i + 1); tick(); end
        InValid = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 1 + VER * 4 || Error !== 1'b0 || wa.size() != 4) begin
            errors++; $display("FAIL wrap_done got lat=%0d err=%b writes=%0d want %0d 0 4", n, Error, wa.size(), 1 + VER * 4);
        end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== ea[i]) begin errors++; $display("FAIL wrap_awr%0d got %0d want %0d", i, wa[i], ea[i]); end
        end
        checks++;
        if (ra.size() != VER * 4) begin errors++; $display("FAIL wrap_reads got %0d want %0d", ra.size(), VER * 4); end
        for (int i = 0; i < ra.size() && i < 4; i++) begin
            checks++;
            if (ra[i] !== ea[i]) begin errors++; $display("FAIL wrap_ard%0d got %0d want %0d", i, ra[i], ea[i]); end
        end
    endtask

    task automatic test_corrupt();
        int n;
        corrupt = 1'b1;
        start(5'd3, 6'd4);
        InValid = 1'b1;
        for (int i = 0; i < 4; i++) begin InData = 32'h5A5A0000 + i; tick(); end
        InValid = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 1 + VER * 4 || Error !== 1'(VER)) begin
            errors++; $display("FAIL corrupt_error got lat=%0d err=%b want %0d %0d", n, Error, 1 + VER * 4, VER);
        end
        tick(); tick();
        checks++;
        if (Error !== 1'(VER)) begin errors++; $display("FAIL corrupt_hold got %b want %0d", Error, VER); end
        corrupt = 1'b0;
        start(5'd0, 6'd0);
        checks++;
        if (Error !== 1'b0 || Done !== 1'b1) begin
            errors++; $display("FAIL corrupt_clear got err=%b done=%b want 0 1", Error, Done);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic bad;
        start(5'd8, 6'd5);
        InValid = 1'b1;
        for (int i = 0; i < 2; i++) begin InData = 32'hC0 + i; tick(); end
        InData = 32'hC2; Rst = 1'b1;
        tick();
        checks++;
        if ({InReady, WrEn, Busy, Done, Error, Awr, Ard1, Din} !== '0) begin
            errors++; $display("FAIL rstmid_outputs got %h want 0", {InReady, WrEn, Busy, Done, Error, Awr, Ard1, Din});
        end
        Rst = 1'b0; InValid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); bad |= Done | Busy | WrEn; end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_quiet got activity=%b want 0", bad); end
        start(5'd8, 6'd2);
        InValid = 1'b1;
        for (int i = 0; i < 2; i++) begin InData = 32'hD0 + i; tick(); end
        InValid = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 1 + VER * 2 || Error !== 1'b0 || wa.size() != 2 || wa[0] !== 5'd8 || wa[1] !== 5'd9) begin
            errors++; $display("FAIL rstmid_restart got lat=%0d err=%b writes=%0d want %0d 0 2 at 8,9", n, Error, wa.size(), 1 + VER * 2);
        end
    endtask

    task automatic test_counts();
        int k;
        start(5'd7, 6'd0);
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || WrEn !== 1'b0) begin
            errors++; $display("FAIL count0_done got done=%b busy=%b we=%b want 1 0 0", Done, Busy, WrEn);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || wa.size() != 0) begin
            errors++; $display("FAIL count0_pulse got done=%b writes=%0d want 0 0", Done, wa.size());
        end
        start(5'd0, 6'd40);
        InValid = 1'b1;
        k = 0;
        while (!Done && k < 100) begin InData = 32'h1000 + k; tick(); k++; end
        InValid = 1'b0;
        checks++;
        if (Done !== 1'b1 || wa.size() != 32 || Error !== 1'b0) begin
            errors++; $display("FAIL count40 got done=%b writes=%0d err=%b want 1 32 0", Done, wa.size(), Error);
        end
        checks++;
        if (wa.size() == 32 && (wa[0] !== 5'd0 || wa[31] !== 5'd31)) begin
            errors++; $display("FAIL count40_addr got first=%0d last=%0d want 0 31", wa[0], wa[31]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_corrupt();
        test_reset_mid();
        test_counts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_loader.md
RF_LOADER -- requirements
Module: rf_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-file address width.
REQ-002 SHALL have parameter DATA_W, default 32, register-file data width.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port BaseAddr  input  ADDR_W  first register written; sampled with Start.
REQ-007 SHALL have port Count  input  ADDR_W+1  number of words to load; sampled with Start.
REQ-008 SHALL have port InData  input  DATA_W  stream data word.
REQ-009 SHALL have port InValid  input  1  stream word valid.
REQ-010 SHALL have port InReady  output  1  loader accepts word this cycle.
REQ-011 SHALL have port Awr  output  ADDR_W  regfile write address.
REQ-012 SHALL have port Din  output  DATA_W  regfile write data.
REQ-013 SHALL have port WrEn  output  1  regfile write enable.
REQ-014 SHALL have port Ard1  output  ADDR_W  regfile read address (verify pass).
REQ-015 SHALL have port Dout1  input  DATA_W  regfile read data; combinational w.r.t. Ard1.
REQ-016 SHALL have ports Busy, Done, Error  output  1 each: operation active, one-cycle completion pulse, verify mismatch flag.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> VERIFY -> IDLE; VERIFY present only per REQ-031.
REQ-018 IDLE: Start=1 SHALL latch BaseAddr and min(Count,32) and enter LOAD next cycle with Busy=1.
REQ-019 Start with Count=0 SHALL stay in IDLE and pulse Done one cycle later, no writes.
REQ-020 LOAD: InReady SHALL be 1 while words remain; a beat is InValid&InReady.
REQ-021 Each beat SHALL produce WrEn=1 next cycle with Awr=current address, Din=InData registered; WrEn=0 otherwise.
REQ-022 Address SHALL increment by 1 per beat, wrapping 31 -> 0 (modulo 2^ADDR_W).
REQ-023 InValid=0 SHALL stall without writes; no timeout.
REQ-024 After the last beat's write cycle, the FSM SHALL enter VERIFY (if compiled) else IDLE with Done pulsed that cycle and Busy=0.
REQ-025 VERIFY: Ard1 SHALL step BaseAddr..BaseAddr+N-1 (wrapping), one address per cycle, first read one cycle after last write.
REQ-026 Checksum SHALL be the XOR of all accepted InData; readback checksum SHALL be the XOR of Dout1 over verified addresses; address 0 SHALL contribute zero to both (hardwired R0).
REQ-027 After the last read, Error SHALL be set if checksums differ, held until next Start; Done pulses same cycle; return to IDLE.
REQ-028 Start while Busy SHALL be ignored.

Reset
REQ-029 Rst=1 at a rising edge SHALL force IDLE and InReady, WrEn, Busy, Done, Error=0, Awr, Ard1, Din=0, checksums=0, on the same edge.
REQ-030 Reset mid-LOAD/VERIFY SHALL abort without a Done pulse; in-flight write SHALL be dropped.

Configuration
REQ-031 Macro RF_LOADER_VERIFY_EN defined: VERIFY state, checksum logic and Error SHALL exist; undefined: LOAD goes directly to IDLE, Ard1 and Error tied 0.

Structure
REQ-032 Package regfile_pkg SHALL hold ADDR_W, DATA_W, NUM_REGS=32 and FSM state encodings.
REQ-033 Checksum accumulator SHALL be sub-module rf_checksum (clear, enable, data in, XOR accumulate out).

Verification
REQ-034 Base=4, Count=3, InData 0x11,0x22,0x33 continuous -> WrEn on 3 consecutive cycles, Awr 4,5,6, Done after, Error=0.
REQ-035 Base=30, Count=4 -> Awr 30,31,0,1; R0 excluded from checksum, Error=0.
REQ-036 InValid toggled 1,0,0,1,1 with Count=3 -> exactly 3 writes, no writes on stall cycles.
REQ-037 Verify on, model corrupts reg 5 readback -> Error=1 with Done; cleared by next Start.
REQ-038 Rst asserted mid-LOAD after 2 of 5 beats -> all outputs 0 next edge, no Done; fresh Start then works.
REQ-039 Count=0 -> Done one cycle after Start, no WrEn; Count=40 -> exactly 32 writes.
